// File: rtl/bus_req_bridge_pkg.sv
// Shared types for the request-stream to register-bus bridge.
package bus_bridge_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_cmd_t;
endpackage

// File: rtl/bus_req_bridge_if.sv
// Request, response and register-bus signals of the bridge; master = bridge side.
interface bus_req_bridge_if;
  import bus_bridge_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [BUS_ADDR_W-1:0] req_addr;
  logic [BUS_DATA_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [BUS_DATA_W-1:0] rsp_rdata;
  logic                  bus_cmd_valid;
  logic                  bus_op;
  logic [BUS_ADDR_W-1:0] bus_addr;
  logic [BUS_DATA_W-1:0] bus_wr_data;
  logic [BUS_DATA_W-1:0] bus_rd_data;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, bus_rd_data,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
           bus_cmd_valid, bus_op, bus_addr, bus_wr_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, bus_rd_data,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
           bus_cmd_valid, bus_op, bus_addr, bus_wr_data
  );
endinterface

// File: rtl/bus_req_bridge_sync_fifo.sv
// Synchronous command FIFO with occupancy count; read data is the current head.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/bus_req_bridge.sv
// Bus master: buffers valid/ready requests and issues them one at a time on the register bus.
//   state | meaning
//   IDLE  | waiting for a queued command; pops head into the bus registers
//   ISSUE | bus strobe cycle; writes and register reads complete here
//   HOLD  | second strobe cycle for RAM reads; read data sampled here
//   RESP  | response presented until rsp_ready
module bus_req_bridge
  import bus_bridge_pkg::*;
#(
  parameter int                    DEPTH    = 4,
  parameter logic [BUS_ADDR_W-1:0] RAM_BASE = 16'h0500
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bus_req_bridge_if.master           bif,
  output logic [$clog2(DEPTH+1)-1:0] cmd_cnt
);
  localparam int CNT_W = $clog2(DEPTH+1);

  state_t                state, state_nxt;
  bus_cmd_t              wr_cmd, head;
  logic                  push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt, cnt_nxt;
  logic                  req_ready_q;
  logic                  cmd_valid_q, cmd_valid_nxt;
  logic                  bus_op_q;
  logic [BUS_ADDR_W-1:0] bus_addr_q;
  logic [BUS_DATA_W-1:0] bus_wr_data_q;
  logic                  rsp_valid_q, rsp_valid_nxt;
  logic                  rsp_write_q, rsp_write_nxt;
  logic [BUS_DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;

  assign push   = bif.req_valid && req_ready_q;
  assign wr_cmd = '{write: bif.req_write, addr: bif.req_addr, wdata: bif.req_wdata};

  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(bus_cmd_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // req_ready is registered from the next occupancy so it is 0 throughout reset.
  always_comb begin
    cnt_nxt = fifo_cnt;
    if (push && !pop)      cnt_nxt = fifo_cnt + CNT_W'(1);
    else if (!push && pop) cnt_nxt = fifo_cnt - CNT_W'(1);
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    cmd_valid_nxt = 1'b0;
    rsp_valid_nxt = rsp_valid_q;
    rsp_write_nxt = rsp_write_q;
    rsp_rdata_nxt = rsp_rdata_q;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          cmd_valid_nxt = 1'b1;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_op_q) begin
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          state_nxt     = RESP;
        end else if (bus_addr_q < RAM_BASE) begin
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b0;
          rsp_rdata_nxt = bif.bus_rd_data;
          state_nxt     = RESP;
        end else begin
          cmd_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        rsp_valid_nxt = 1'b1;
        rsp_write_nxt = 1'b0;
        rsp_rdata_nxt = bif.bus_rd_data;
        state_nxt     = RESP;
      end
      RESP: begin
        if (bif.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      bus_op_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state       <= state_nxt;
      req_ready_q <= (cnt_nxt != CNT_W'(DEPTH));
      cmd_valid_q <= cmd_valid_nxt;
      if (pop) begin
        bus_op_q      <= head.write;
        bus_addr_q    <= head.addr;
        bus_wr_data_q <= head.wdata;
      end
      rsp_valid_q <= rsp_valid_nxt;
      rsp_write_q <= rsp_write_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
    end
  end

  assign bif.req_ready     = req_ready_q;
  assign bif.bus_cmd_valid = cmd_valid_q;
  assign bif.bus_op        = bus_op_q;
  assign bif.bus_addr      = bus_addr_q;
  assign bif.bus_wr_data   = bus_wr_data_q;
  assign bif.rsp_valid     = rsp_valid_q;
  assign bif.rsp_write     = rsp_write_q;
  assign bif.rsp_rdata     = rsp_rdata_q;
  assign cmd_cnt           = fifo_cnt;
endmodule

// File: tb/tb_bus_req_bridge.sv
// Directed bench for bus_req_bridge with a small register/RAM bus model.
module tb_bus_req_bridge;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cmd_cnt;
  int         tests = 0;
  int         failed = 0;

  bus_req_bridge_if bif();

  bus_req_bridge #(.DEPTH(4), .RAM_BASE(16'h0500)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bif     (bif),
    .cmd_cnt (cmd_cnt)
  );

  always #5 clk = ~clk;

  // Bus slave model: RAM data (>= 0x0500) is only valid on the second strobe cycle.
  logic [15:0] mem [256];
  logic        mem_loaded = 1'b0;
  logic        prev_strobe = 1'b0;

  always @(posedge clk) begin
    prev_strobe <= bif.bus_cmd_valid;
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      for (int i = 0; i < 5; i++) mem[8'(48 + i)] <= 16'(4096 + i);
      mem_loaded <= 1'b1;
    end else if (bif.bus_cmd_valid && bif.bus_op) begin
      mem[bif.bus_addr[7:0]] <= bif.bus_wr_data;
    end
  end

  assign bif.bus_rd_data = (bif.bus_addr >= 16'h0500 && !prev_strobe) ? 16'hDEAD
                                                                       : mem[bif.bus_addr[7:0]];

  task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_write = w; bif.req_addr = a; bif.req_wdata = d;
    while (!bif.req_ready && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (bif.req_ready !== 1'b1) begin failed++; $display("FAIL push_ready addr=%h: got %b want 1", a, bif.req_ready); end
    @(posedge clk);
    @(negedge clk);
    bif.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bif.req_ready, bif.rsp_valid, bif.rsp_write, bif.bus_cmd_valid, bif.bus_op} !== 5'b0) begin
      failed++; $display("FAIL reset_ctrl: got %b want 00000", {bif.req_ready, bif.rsp_valid, bif.rsp_write, bif.bus_cmd_valid, bif.bus_op});
    end
    tests++;
    if ({bif.bus_addr, bif.bus_wr_data, bif.rsp_rdata} !== 48'h0) begin
      failed++; $display("FAIL reset_data: got %h want 0", {bif.bus_addr, bif.bus_wr_data, bif.rsp_rdata});
    end
    tests++;
    if (cmd_cnt !== 3'd0) begin failed++; $display("FAIL reset_cnt: got %0d want 0", cmd_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bif.req_ready !== 1'b1) begin failed++; $display("FAIL reset_release_ready: got %b want 1", bif.req_ready); end
  endtask

  task automatic test_write_reg();
    bif.rsp_ready = 1'b1;
    push(1'b1, 16'h0009, 16'h0001);
    tests++;
    if ({bif.bus_cmd_valid, cmd_cnt} !== {1'b0, 3'd1}) begin
      failed++; $display("FAIL wr_t1: got valid=%b cnt=%0d want valid=0 cnt=1", bif.bus_cmd_valid, cmd_cnt);
    end
    @(negedge clk);
    tests++;
    if ({bif.bus_cmd_valid, bif.bus_op, bif.bus_addr, bif.bus_wr_data, cmd_cnt} !== {1'b1, 1'b1, 16'h0009, 16'h0001, 3'd0}) begin
      failed++; $display("FAIL wr_strobe: got v=%b op=%b a=%h d=%h cnt=%0d want 1 1 0009 0001 0",
                         bif.bus_cmd_valid, bif.bus_op, bif.bus_addr, bif.bus_wr_data, cmd_cnt);
    end
    @(negedge clk);
    tests++;
    if ({bif.bus_cmd_valid, bif.rsp_valid, bif.rsp_write, bif.rsp_rdata} !== {1'b0, 1'b1, 1'b1, 16'h0000}) begin
      failed++; $display("FAIL wr_rsp: got v=%b rv=%b rw=%b rd=%h want 0 1 1 0000",
                         bif.bus_cmd_valid, bif.rsp_valid, bif.rsp_write, bif.rsp_rdata);
    end
    @(negedge clk);
    tests++;
    if (bif.rsp_valid !== 1'b0) begin failed++; $display("FAIL wr_rsp_done: got %b want 0", bif.rsp_valid); end
  endtask

  task automatic test_read_reg();
    push(1'b0, 16'h0009, 16'h0000);
    @(negedge clk);
    tests++;
    if ({bif.bus_cmd_valid, bif.bus_op} !== 2'b10) begin
      failed++; $display("FAIL rd_strobe: got v=%b op=%b want 1 0", bif.bus_cmd_valid, bif.bus_op);
    end
    @(negedge clk);
    tests++;
    if ({bif.bus_cmd_valid, bif.rsp_valid, bif.rsp_write, bif.rsp_rdata} !== {1'b0, 1'b1, 1'b0, 16'h0001}) begin
      failed++; $display("FAIL rd_rsp: got v=%b rv=%b rw=%b rd=%h want 0 1 0 0001",
                         bif.bus_cmd_valid, bif.rsp_valid, bif.rsp_write, bif.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_ram();
    push(1'b1, 16'h0510, 16'hA5A5);
    repeat (3) @(negedge clk);
    push(1'b0, 16'h0510, 16'h0000);
    @(negedge clk);
    tests++;
    if ({bif.bus_cmd_valid, bif.bus_op} !== 2'b10) begin
      failed++; $display("FAIL ram_strobe1: got v=%b op=%b want 1 0", bif.bus_cmd_valid, bif.bus_op);
    end
    @(negedge clk);
    tests++;
    if ({bif.bus_cmd_valid, bif.rsp_valid, bif.bus_addr} !== {1'b1, 1'b0, 16'h0510}) begin
      failed++; $display("FAIL ram_hold: got v=%b rv=%b a=%h want 1 0 0510", bif.bus_cmd_valid, bif.rsp_valid, bif.bus_addr);
    end
    @(negedge clk);
    tests++;
    if ({bif.bus_cmd_valid, bif.rsp_valid, bif.rsp_write, bif.rsp_rdata} !== {1'b0, 1'b1, 1'b0, 16'hA5A5}) begin
      failed++; $display("FAIL ram_rsp: got v=%b rv=%b rw=%b rd=%h want 0 1 0 a5a5",
                         bif.bus_cmd_valid, bif.rsp_valid, bif.rsp_write, bif.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [6];
    int          rsp_cyc [6];
    int          idx = 0, strobes = 0;
    logic        unstable = 1'b0, accept_next = 1'b0, order_bad = 1'b0, gap_bad = 1'b0;
    exp_d[0] = 16'h0001;
    for (int i = 1; i < 6; i++) exp_d[i] = 16'(4096 + i - 1);
    bif.rsp_ready = 1'b0;
    push(1'b0, 16'h0009, 16'h0000);
    repeat (2) @(negedge clk);
    tests++;
    if (bif.rsp_valid !== 1'b1) begin failed++; $display("FAIL b2b_stall_rsp: got %b want 1", bif.rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_addr = 16'(48 + i);
      @(posedge clk);
    end
    @(negedge clk);
    bif.req_addr = 16'h0034;
    tests++;
    if ({bif.req_ready, cmd_cnt} !== {1'b0, 3'd4}) begin
      failed++; $display("FAIL b2b_full: got ready=%b cnt=%0d want ready=0 cnt=4", bif.req_ready, cmd_cnt);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bif.bus_cmd_valid) strobes++;
      if ({bif.rsp_valid, bif.rsp_write, bif.rsp_rdata} !== {1'b1, 1'b0, 16'h0001}) unstable = 1'b1;
    end
    tests++;
    if (strobes != 0) begin failed++; $display("FAIL stall_no_strobe: got %0d strobes want 0", strobes); end
    tests++;
    if (unstable) begin failed++; $display("FAIL stall_rsp_stable: got changing rsp want stable 1/0/0001"); end
    tests++;
    if ({bif.req_ready, cmd_cnt} !== {1'b0, 3'd4}) begin
      failed++; $display("FAIL b2b_fifth_waits: got ready=%b cnt=%0d want ready=0 cnt=4", bif.req_ready, cmd_cnt);
    end
    bif.rsp_ready = 1'b1;
    for (int c = 0; c < 60 && idx < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (accept_next) bif.req_valid = 1'b0;
      accept_next = bif.req_valid && bif.req_ready;
      if (bif.rsp_valid) begin
        if (bif.rsp_rdata !== exp_d[idx] || bif.rsp_write !== 1'b0) begin
          order_bad = 1'b1;
          $display("rsp %0d: got %h want %h", idx, bif.rsp_rdata, exp_d[idx]);
        end
        rsp_cyc[idx] = c;
        idx++;
      end
    end
    bif.req_valid = 1'b0;
    tests++;
    if (idx != 6) begin failed++; $display("FAIL b2b_rsp_count: got %0d want 6", idx); end
    tests++;
    if (order_bad) begin failed++; $display("FAIL b2b_order: got out-of-order data want push order"); end
    for (int i = 1; i < idx; i++) if (rsp_cyc[i] - rsp_cyc[i-1] != 3) gap_bad = 1'b1;
    tests++;
    if (gap_bad) begin failed++; $display("FAIL b2b_gap: got response spacing other than 3 want 3"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] addrs [4];
    logic        prev_seen = 1'b0, found = 1'b0;
    int          rsps = 0, strobes = 0;
    addrs[0] = 16'h0510; addrs[1] = 16'h0030; addrs[2] = 16'h0031; addrs[3] = 16'h0032;
    bif.rsp_ready = 1'b0;
    push(1'b0, 16'h0009, 16'h0000);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_addr = addrs[i];
      @(posedge clk);
    end
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bif.bus_cmd_valid && prev_seen) found = 1'b1;
      prev_seen = bif.bus_cmd_valid;
    end
    tests++;
    if (!found) begin failed++; $display("FAIL mid_hold_seen: got no HOLD within 20 cycles want HOLD"); end
    tests++;
    if (cmd_cnt !== 3'd3) begin failed++; $display("FAIL mid_hold_cnt: got %0d want 3", cmd_cnt); end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({bif.req_ready, bif.rsp_valid, bif.rsp_write, bif.bus_cmd_valid, bif.bus_op, cmd_cnt} !== 8'b0) begin
      failed++; $display("FAIL mid_reset_ctrl: got rdy=%b rv=%b rw=%b v=%b op=%b cnt=%0d want all 0",
                         bif.req_ready, bif.rsp_valid, bif.rsp_write, bif.bus_cmd_valid, bif.bus_op, cmd_cnt);
    end
    tests++;
    if ({bif.bus_addr, bif.bus_wr_data, bif.rsp_rdata} !== 48'h0) begin
      failed++; $display("FAIL mid_reset_data: got %h want 0", {bif.bus_addr, bif.bus_wr_data, bif.rsp_rdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bif.rsp_valid) rsps++;
      if (bif.bus_cmd_valid) strobes++;
    end
    tests++;
    if (rsps + strobes != 0) begin
      failed++; $display("FAIL mid_discard: got %0d rsp %0d strobe cycles want 0", rsps, strobes);
    end
    tests++;
    if ({bif.req_ready, cmd_cnt} !== {1'b1, 3'd0}) begin
      failed++; $display("FAIL mid_after: got ready=%b cnt=%0d want 1 0", bif.req_ready, cmd_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.rsp_ready = 1'b0;
    test_reset();
    test_write_reg();
    test_read_reg();
    test_ram();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
